// File: rtl/strait_bist_pkg.sv
// Shared types and default parameters for the STRAIT BIST compare-path sequencer.
// Optional failure logging is enabled with the STRAIT_BIST_FAIL_LOG_EN macro.
package strait_bist_pkg;

  localparam int DEF_NUM_PATTERNS = 16;
  localparam int DEF_IDX_W        = 4;
  localparam int DEF_PIPE_LAT     = 3;
  localparam int DEF_CNT_W        = 8;
  localparam int DATA_W           = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/strait_bist_sequencer_if.sv
// Bus between the test-mode controller / array / ROM side (master) and the
// BIST sequencer (slave).
interface strait_bist_sequencer_if
  import strait_bist_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic              start;
  logic              abort;
  logic [IDX_W-1:0]  pat_idx;
  logic              pat_valid;
  logic [IDX_W-1:0]  rom_addr;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] accum_out;
  logic              busy;
  logic              done;
  logic              fail;
  logic [CNT_W-1:0]  fail_count;
  logic [IDX_W-1:0]  first_fail_idx;

  modport master (
    output start, abort, expected, accum_out,
    input  pat_idx, pat_valid, rom_addr, busy, done, fail, fail_count, first_fail_idx
  );

  modport slave (
    input  start, abort, expected, accum_out,
    output pat_idx, pat_valid, rom_addr, busy, done, fail, fail_count, first_fail_idx
  );

endinterface

// File: rtl/strait_bist_checker.sv
// Registered 32-bit compare with sticky fail flag; under STRAIT_BIST_FAIL_LOG_EN
// also a saturating mismatch counter and a first-failing-index latch.
module strait_bist_checker
  import strait_bist_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              cmp_en_i,
  input  logic [IDX_W-1:0]  cmp_idx_i,
  input  logic [DATA_W-1:0] expected_i,
  input  logic [DATA_W-1:0] accum_i,
  output logic              fail_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic [IDX_W-1:0]  first_fail_idx_o
);

  logic mismatch;
  logic fail_q;

  // Zero is ordinary data: only the enable qualifies a compare.
  assign mismatch = cmp_en_i && (accum_i != expected_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q <= 1'b0;
    end else if (clear_i) begin
      fail_q <= 1'b0;
    end else if (mismatch) begin
      fail_q <= 1'b1;
    end
  end

  assign fail_o = fail_q;

`ifdef STRAIT_BIST_FAIL_LOG_EN
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] first_q;

  // fail_q still low means this is the first mismatch of the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      first_q <= '0;
    end else if (mismatch) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (!fail_q) begin
        first_q <= cmp_idx_i;
      end
    end
  end

  assign fail_count_o     = cnt_q;
  assign first_fail_idx_o = first_q;
`else
  logic unused_idx;
  assign unused_idx       = ^cmp_idx_i;
  assign fail_count_o     = '0;
  assign first_fail_idx_o = '0;
`endif

endmodule

// File: rtl/strait_bist_sequencer.sv
// STRAIT BIST sequencer: issues pattern indices, ROM reads aligned to the array
// latency, and feeds the checker. Failure logging via STRAIT_BIST_FAIL_LOG_EN.
module strait_bist_sequencer
  import strait_bist_pkg::*;
#(
  parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int PIPE_LAT     = DEF_PIPE_LAT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  strait_bist_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_run;
  logic             flush;
  logic             pat_valid;
  logic             cmp_en;
  logic             cmp_last;

  // Issue-time delay line: stage j holds what was issued j+1 cycles ago.
  logic [PIPE_LAT-1:0] dl_valid_q;
  logic [PIPE_LAT-1:0] dl_last_q;
  logic [IDX_W-1:0]    dl_idx_q [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_run = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = RUN;
          idx_d     = '0;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          flush   = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (cmp_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pat_valid = (state_q == RUN);

  // An abort drops all in-flight compares so partial results stay frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_idx_q[i] <= '0;
    end else begin
      if (flush) begin
        dl_valid_q <= '0;
        dl_last_q  <= '0;
      end else begin
        dl_valid_q <= {dl_valid_q[PIPE_LAT-2:0], pat_valid};
        dl_last_q  <= {dl_last_q[PIPE_LAT-2:0], pat_valid && (idx_q == LAST_IDX)};
      end
      dl_idx_q[0] <= idx_q;
      for (int i = 1; i < PIPE_LAT; i++) dl_idx_q[i] <= dl_idx_q[i-1];
    end
  end

  assign cmp_en   = dl_valid_q[PIPE_LAT-1];
  assign cmp_last = cmp_en && dl_last_q[PIPE_LAT-1];

  assign bus.pat_idx   = idx_q;
  assign bus.pat_valid = pat_valid;
  assign bus.rom_addr  = dl_idx_q[PIPE_LAT-2];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

  strait_bist_checker #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (start_run),
    .cmp_en_i         (cmp_en),
    .cmp_idx_i        (dl_idx_q[PIPE_LAT-1]),
    .expected_i       (bus.expected),
    .accum_i          (bus.accum_out),
    .fail_o           (bus.fail),
    .fail_count_o     (bus.fail_count),
    .first_fail_idx_o (bus.first_fail_idx)
  );

endmodule

// File: tb/tb_strait_bist_sequencer.sv
// Self-checking bench for strait_bist_sequencer: ROM/array models, vector table,
// done-time scoreboard and hand-written abort/reset/re-start sequences.
module tb_strait_bist_sequencer;
  import strait_bist_pkg::*;

`ifdef STRAIT_BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  strait_bist_sequencer_if #(.IDX_W(4), .CNT_W(8)) busA ();
  strait_bist_sequencer_if #(.IDX_W(4), .CNT_W(3)) busB ();

  strait_bist_sequencer #(.NUM_PATTERNS(16), .IDX_W(4), .PIPE_LAT(3), .CNT_W(8))
    dutA (.clk(clk), .rst(rst), .bus(busA));
  strait_bist_sequencer #(.NUM_PATTERNS(16), .IDX_W(4), .PIPE_LAT(3), .CNT_W(3))
    dutB (.clk(clk), .rst(rst), .bus(busB));

  logic        startIn = 1'b0;
  logic        abortIn = 1'b0;
  logic [31:0] romMem [16];
  logic [15:0] badMask = '0;
  logic [31:0] badVal = '0;
  logic [3:0]  pIdx [3];
  logic [31:0] expWord = '0;
  logic [31:0] accumWord;

  assign busA.start = startIn;
  assign busB.start = startIn;
  assign busA.abort = abortIn;
  assign busB.abort = abortIn;
  assign busA.expected = expWord;
  assign busB.expected = expWord;
  assign busA.accum_out = accumWord;
  assign busB.accum_out = accumWord;

  // 1-cycle synchronous ROM and a 3-deep array pipeline that echoes the ROM
  // except at indices flagged in badMask.
  always @(posedge clk) begin
    expWord <= romMem[busA.rom_addr];
    pIdx[0] <= busA.pat_idx;
    pIdx[1] <= pIdx[0];
    pIdx[2] <= pIdx[1];
  end
  always_comb accumWord = badMask[pIdx[2]] ? badVal : romMem[pIdx[2]];

  int cycleCount = 0;
  int startCycle = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] rom0;
    logic [15:0] mask;
    logic [31:0] val;
    bit          expFail;
    int          expCnt;
    int          expFirst;
  } vec_t;
  vec_t vecs [5];

  typedef struct {
    bit fail;
    int cntA;
    int cntB;
    int first;
  } exp_t;
  exp_t sb [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && busA.done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(busA.done), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_cycle", 32'(cycleCount - startCycle), 32'd20);
        checkOutput("done_B", 32'(busB.done), 32'h1);
        checkOutput("fail_A", 32'(busA.fail), 32'(e.fail));
        checkOutput("fail_B", 32'(busB.fail), 32'(e.fail));
        checkOutput("fail_count_A", 32'(busA.fail_count), 32'(e.cntA));
        checkOutput("fail_count_B", 32'(busB.fail_count), 32'(e.cntB));
        checkOutput("first_fail_idx", 32'(busA.first_fail_idx), 32'(e.first));
      end
    end
  end

  task automatic fillVec(input int i, input string n, input logic [31:0] r0, input logic [15:0] m,
                         input logic [31:0] v, input bit f, input int c, input int fi);
    vecs[i].name = n; vecs[i].rom0 = r0; vecs[i].mask = m; vecs[i].val = v;
    vecs[i].expFail = f; vecs[i].expCnt = c; vecs[i].expFirst = fi;
  endtask

  task automatic setupVec(input int i);
    romMem[0] = vecs[i].rom0;
    for (int k = 1; k < 16; k++) romMem[k] = 32'(k);
    badMask = vecs[i].mask;
    badVal  = vecs[i].val;
  endtask

  function automatic exp_t expOf(input int i);
    exp_t e;
    e.fail  = vecs[i].expFail;
    e.cntA  = LOG ? vecs[i].expCnt : 0;
    e.cntB  = LOG ? ((vecs[i].expCnt > 7) ? 7 : vecs[i].expCnt) : 0;
    e.first = LOG ? vecs[i].expFirst : 0;
    return e;
  endfunction

  task automatic startRun(input bit doPush, input exp_t e);
    @(negedge clk);
    if (doPush) sb.push_back(e);
    startIn = 1'b1;
    startCycle = cycleCount;
    @(negedge clk);
    startIn = 1'b0;
  endtask

  task automatic waitRel(input int c);
    while ((cycleCount - startCycle) < c) @(negedge clk);
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    checkOutput({name, "_pending"}, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic applyStimulus(input int i);
    setupVec(i);
    startRun(1'b1, expOf(i));
    waitDone(vecs[i].name);
    waitRel(21);
    checkOutput({vecs[i].name, "_busy_after"}, 32'(busA.busy), 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pat_idx"}, 32'(busA.pat_idx), 32'h0);
    checkOutput({tag, "_pat_valid"}, 32'(busA.pat_valid), 32'h0);
    checkOutput({tag, "_rom_addr"}, 32'(busA.rom_addr), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busA.busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(busA.done), 32'h0);
    checkOutput({tag, "_fail"}, 32'(busA.fail), 32'h0);
    checkOutput({tag, "_fail_count"}, 32'(busA.fail_count), 32'h0);
    checkOutput({tag, "_first_fail_idx"}, 32'(busA.first_fail_idx), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    fillVec(0, "echo",        32'h0, 16'h0000, 32'h0,        1'b0, 0,  0);
    fillVec(1, "corrupt5",    32'h0, 16'h0020, 32'hDEADBEEF, 1'b1, 1,  5);
    fillVec(2, "zero_match",  32'h0, 16'h0001, 32'h0,        1'b0, 0,  0);
    fillVec(3, "zero_vs_one", 32'h1, 16'h0001, 32'h0,        1'b1, 1,  0);
    fillVec(4, "all_bad",     32'h0, 16'hFFFF, 32'hDEADBEEF, 1'b1, 16, 0);
    setupVec(0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // Issue/ROM timing and an ignored start re-pulse during the run.
    setupVec(0);
    startRun(1'b1, expOf(0));
    waitRel(1);
    checkOutput("c1_pat_valid", 32'(busA.pat_valid), 32'h1);
    checkOutput("c1_pat_idx", 32'(busA.pat_idx), 32'h0);
    checkOutput("c1_busy", 32'(busA.busy), 32'h1);
    waitRel(3);
    checkOutput("c3_rom_addr", 32'(busA.rom_addr), 32'h0);
    waitRel(8);
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    waitRel(16);
    checkOutput("c16_pat_idx", 32'(busA.pat_idx), 32'hF);
    checkOutput("c16_pat_valid", 32'(busA.pat_valid), 32'h1);
    waitRel(17);
    checkOutput("c17_pat_valid", 32'(busA.pat_valid), 32'h0);
    waitRel(18);
    checkOutput("c18_rom_addr", 32'(busA.rom_addr), 32'hF);
    waitRel(19);
    checkOutput("c19_done", 32'(busA.done), 32'h0);
    waitDone("restart");
    waitRel(21);
    checkOutput("restart_busy_c21", 32'(busA.busy), 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("restart_no_rerun", 32'(busA.busy), 32'h0);

    // Abort in cycle 10 after the index-5 mismatch has been registered.
    setupVec(1);
    startRun(1'b0, e);
    waitRel(10);
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    checkOutput("abort_busy", 32'(busA.busy), 32'h0);
    checkOutput("abort_fail", 32'(busA.fail), 32'h1);
    checkOutput("abort_fail_count", 32'(busA.fail_count), LOG ? 32'h1 : 32'h0);
    checkOutput("abort_first_idx", 32'(busA.first_fail_idx), LOG ? 32'h5 : 32'h0);
    repeat (25) @(negedge clk);
    checkOutput("abort_idle", 32'(busA.busy), 32'h0);

    // abort together with start in IDLE keeps the FSM idle and fail untouched.
    startIn = 1'b1;
    abortIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    abortIn = 1'b0;
    checkOutput("abort_start_busy", 32'(busA.busy), 32'h0);
    checkOutput("abort_start_fail", 32'(busA.fail), 32'h1);

    // Reset in cycle 12 after a mismatch, then a clean run.
    setupVec(1);
    startRun(1'b0, e);
    waitRel(12);
    checkOutput("pre_rst_fail", 32'(busA.fail), 32'h1);
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
